stack_cmd_sequencer: RTL and testbench
======================================

STACK_CMD_SEQUENCER -- requirements
Module: stack_cmd_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data word width; must equal the stack's data width.
REQ-002 SHALL have parameter DEPTH, default 5, stack entries; must equal the stack's depth.
REQ-003 SHALL have parameter IDXW, default 3, INDEX width.
REQ-004 SHALL have port CLK  input  1  single clock; all state changes on rising edge except the capture latch (REQ-014).
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port REQ_VALID  input  1  request present.
REQ-007 SHALL have port REQ_READY  output  1  request accepted when REQ_VALID and REQ_READY are both high at a rising edge.
REQ-008 SHALL have port REQ_OP  input  2  01 push, 10 pop, 11 get-at-index; 00 is ignored and never accepted.
REQ-009 SHALL have port REQ_DATA  input  WIDTH  push operand.
REQ-010 SHALL have port REQ_INDEX  input  IDXW  get offset from top; 0 = top.
REQ-011 SHALL have ports RSP_VALID  output  1 (one-cycle pulse), RSP_DATA  output  WIDTH, and RSP_ERR  output  1.
REQ-012 SHALL have ports COMMAND  output  2, INDEX  output  IDXW, and IO_DATA  inout  WIDTH, all toward the stack.

Function
REQ-013 SHALL implement the FSM IDLE -> ISSUE -> (push: RESP | pop/get: CAPTURE -> RESP) -> IDLE.
- REQ_READY is high only in IDLE.
- COMMAND, INDEX and the IO_DATA driver are registered.
REQ-014 SHALL drive the stack bus per state:
- ISSUE: COMMAND = accepted op, INDEX = accepted index.
- ISSUE, push only: IO_DATA is driven with REQ_DATA captured at accept.
- All other states: COMMAND = 00 and IO_DATA = high-Z.
REQ-015 SHALL capture read data in CAPTURE with a level-sensitive latch.
- The latch is transparent while CLK = 1 and holds on the CLK falling edge.
- The value is transferred to RSP_DATA at the next rising edge.
REQ-016 SHALL meet this timing, with the accept edge at T0:
- Push: RSP_VALID high T1..T2, RSP_DATA unchanged.
- Pop/get: RSP_VALID high T2..T3.
- REQ_READY returns on the edge that ends RSP_VALID.
REQ-017 SHALL keep occupancy counter OCC, 0..DEPTH, width $clog2(DEPTH+1), updated at the edge leaving ISSUE.
- Push increments OCC, saturating at DEPTH.
- Pop decrements OCC, saturating at 0.
- Get leaves OCC unchanged.
REQ-018 SHALL never drive IO_DATA in any cycle where COMMAND is not 01; there is no bus contention.
REQ-019 SHALL ignore REQ_* changes after acceptance; operands are latched at the accept edge.
REQ-020 SHALL hold RSP_ERR = 0 in every RSP_VALID cycle unless REQ-025 applies.

Reset
REQ-021 SHALL, on RESET asserted at any time including mid-operation, immediately enter this state:
- FSM = IDLE, COMMAND = 00, INDEX = 0, IO_DATA = high-Z.
- RSP_VALID = 0, RSP_DATA = 0, RSP_ERR = 0, OCC = 0.
- REQ_READY = 1.
REQ-022 SHALL produce no RSP_VALID for an operation interrupted by reset.
REQ-023 SHALL accept a request on the first rising edge after RESET deasserts.

Configuration
REQ-024 SHALL provide macro STACK_SEQ_GUARD_EN.
REQ-025 SHALL, with STACK_SEQ_GUARD_EN defined, reject the following in IDLE:
- Push when OCC = DEPTH.
- Pop when OCC = 0.
- Get when REQ_INDEX >= OCC.
- A rejected request skips ISSUE: RESP follows at T1 with RSP_ERR = 1, RSP_DATA = 0, COMMAND stays 00, OCC unchanged.
REQ-026 SHALL, without STACK_SEQ_GUARD_EN, forward every request to the stack and hold RSP_ERR tied to 0; the stack then wraps.

Structure
REQ-027 SHALL place in shared package stack_pkg:
- Opcode enum: NOP = 00, PUSH = 01, POP = 10, GET = 11.
- FSM state enum.
- Defaults for WIDTH, DEPTH and IDXW.
REQ-028 SHALL isolate the read latch as sub-module stack_seq_capture_latch.

Verification
REQ-029 SHALL pass: reset; push 3, push 9, pop -> push RSP_VALID at T1; pop RSP_DATA = 9 at T2; OCC = 1.
REQ-030 SHALL pass: push 1, 2, 3; get index 2 -> RSP_DATA = 1; OCC = 3.
REQ-031 SHALL pass: guard on, pop from empty -> RSP_ERR = 1 at T1, COMMAND stays 00; guard off -> pop forwarded, RSP_ERR = 0.
REQ-032 SHALL pass: guard on, six pushes -> sixth has RSP_ERR = 1, OCC = 5; guard off -> OCC = 5, stack wraps.
REQ-033 SHALL pass: RESET pulsed during CAPTURE -> IO_DATA high-Z, no RSP_VALID, REQ_READY = 1, then push 7 and pop returns 7.
REQ-034 SHALL pass: REQ_VALID held with REQ_OP = 00 -> never accepted, COMMAND stays 00.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared opcode/state types and default sizes for the stack command sequencer slice.
package stack_pkg;

   localparam int unsigned STACK_WIDTH = 4;
   localparam int unsigned STACK_DEPTH = 5;
   localparam int unsigned STACK_IDXW  = 3;

   typedef enum logic [1:0] {
      NOP  = 2'b00,
      PUSH = 2'b01,
      POP  = 2'b10,
      GET  = 2'b11
   } stack_op_e;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } seq_state_e;

endpackage

// File: rtl/stack_seq_capture_latch.sv
// Read-data capture latch: transparent while CLK is high and enabled, holds from the falling edge.
module stack_seq_capture_latch
   import stack_pkg::*;
#(
   parameter int unsigned WIDTH = STACK_WIDTH
) (
   input  logic             CLK,
   input  logic             enable,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_latch begin
      if (CLK && enable) q <= d;
   end

endmodule

// File: rtl/stack_cmd_sequencer.sv
// Sequences push/pop/get requests onto a shared-bus stack and returns one response per request.
// Optional occupancy guard: define STACK_SEQ_GUARD_EN to reject overflow/underflow/out-of-range gets.
module stack_cmd_sequencer
   import stack_pkg::*;
#(
   parameter int unsigned WIDTH = STACK_WIDTH,
   parameter int unsigned DEPTH = STACK_DEPTH,
   parameter int unsigned IDXW  = STACK_IDXW
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             REQ_VALID,
   output logic             REQ_READY,
   input  logic [1:0]       REQ_OP,
   input  logic [WIDTH-1:0] REQ_DATA,
   input  logic [IDXW-1:0]  REQ_INDEX,
   output logic             RSP_VALID,
   output logic [WIDTH-1:0] RSP_DATA,
   output logic             RSP_ERR,
   output logic [1:0]       COMMAND,
   output logic [IDXW-1:0]  INDEX,
   inout  logic [WIDTH-1:0] IO_DATA
);

   localparam int unsigned     OCCW    = $clog2(DEPTH + 1);
   localparam logic [OCCW-1:0] OCC_MAX = OCCW'(DEPTH);

   seq_state_e       state;
   stack_op_e        op_q;
   logic [OCCW-1:0]  occ;
   logic [WIDTH-1:0] io_drv;
   logic             io_en;
   logic             rej_q;
   logic             reject;
   logic             req_fire;
   logic [WIDTH-1:0] latch_q;

   assign REQ_READY = (state == IDLE);
   assign req_fire  = REQ_VALID && (REQ_OP != 2'b00);
   assign IO_DATA   = io_en ? io_drv : 'z;

`ifdef STACK_SEQ_GUARD_EN
   always_comb begin
      reject = 1'b0;
      case (REQ_OP)
         PUSH:    reject = (occ == OCC_MAX);
         POP:     reject = (occ == '0);
         GET:     reject = (32'(REQ_INDEX) >= 32'(occ));
         default: reject = 1'b0;
      endcase
   end
`else
   assign reject = 1'b0;
`endif

   stack_seq_capture_latch #(.WIDTH(WIDTH)) u_capture (
      .CLK    (CLK),
      .enable (state == CAPTURE),
      .d      (IO_DATA),
      .q      (latch_q)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         op_q      <= NOP;
         occ       <= '0;
         rej_q     <= 1'b0;
         COMMAND   <= NOP;
         INDEX     <= '0;
         io_drv    <= '0;
         io_en     <= 1'b0;
         RSP_VALID <= 1'b0;
         RSP_DATA  <= '0;
         RSP_ERR   <= 1'b0;
      end else begin
         COMMAND   <= NOP;
         INDEX     <= '0;
         io_en     <= 1'b0;
         RSP_VALID <= 1'b0;
         case (state)
            IDLE: begin
               if (req_fire) begin
                  op_q <= stack_op_e'(REQ_OP);
                  if (reject) begin
                     rej_q <= 1'b1;
                     state <= RESP;
                  end else begin
                     state   <= ISSUE;
                     COMMAND <= REQ_OP;
                     INDEX   <= REQ_INDEX;
                     io_drv  <= REQ_DATA;
                     io_en   <= (REQ_OP == PUSH);
                  end
               end
            end
            ISSUE: begin
               case (op_q)
                  PUSH:    if (occ != OCC_MAX) occ <= occ + 1'b1;
                  POP:     if (occ != '0) occ <= occ - 1'b1;
                  default: ;
               endcase
               if (op_q == PUSH) begin
                  state     <= RESP;
                  RSP_VALID <= 1'b1;
                  RSP_ERR   <= 1'b0;
               end else begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               state     <= RESP;
               RSP_VALID <= 1'b1;
               RSP_DATA  <= latch_q;
               RSP_ERR   <= 1'b0;
            end
            RESP: begin
               // A rejected request spends two cycles here so its response lands one edge after accept.
               if (rej_q) begin
                  rej_q     <= 1'b0;
                  RSP_VALID <= 1'b1;
                  RSP_DATA  <= '0;
                  RSP_ERR   <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Bench for stack_cmd_sequencer: behavioural stack on the bus plus a queue reference model.
// Define STACK_SEQ_GUARD_EN for both bench and RTL to exercise the guarded build.
module tb_stack_cmd_sequencer;

   localparam int W  = 4;
   localparam int D  = 5;
   localparam int IW = 3;
   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_PUSH = 2'b01;
   localparam logic [1:0] OP_POP  = 2'b10;
   localparam logic [1:0] OP_GET  = 2'b11;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_op = 2'b00;
   logic [W-1:0]  req_data = '0;
   logic [IW-1:0] req_index = '0;
   logic          rsp_valid;
   logic [W-1:0]  rsp_data;
   logic          rsp_err;
   logic [1:0]    command;
   logic [IW-1:0] index;
   wire  [W-1:0]  io_data;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int            waited;
      int            lat;
      logic [W-1:0]  rdata;
      logic          rerr;
      logic [1:0]    cmd;
      logic [IW-1:0] idx;
      logic          vld_after;
      logic          ready_after;
      logic          busy_ok;
   } obs_t;

   always #5 clk = ~clk;

   stack_cmd_sequencer #(.WIDTH(W), .DEPTH(D), .IDXW(IW)) dut (
      .CLK(clk), .RESET(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_OP(req_op),
      .REQ_DATA(req_data), .REQ_INDEX(req_index), .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data),
      .RSP_ERR(rsp_err), .COMMAND(command), .INDEX(index), .IO_DATA(io_data)
   );

   // Behavioural stack: circular storage, answers reads on the bus in the cycle after the command.
   logic [W-1:0] stk_mem [D];
   int           stk_wp;
   logic         stk_en;
   logic [W-1:0] stk_drv;
   assign io_data = stk_en ? stk_drv : 'z;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stk_en <= 1'b0;
         stk_wp <= 0;
      end else begin
         stk_en <= 1'b0;
         case (command)
            OP_PUSH: begin
               stk_mem[stk_wp] <= io_data;
               stk_wp          <= (stk_wp + 1) % D;
            end
            OP_POP: begin
               stk_wp  <= (stk_wp + D - 1) % D;
               stk_drv <= stk_mem[(stk_wp + D - 1) % D];
               stk_en  <= 1'b1;
            end
            OP_GET: begin
               stk_drv <= stk_mem[(((stk_wp - 1 - int'(index)) % D) + D) % D];
               stk_en  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         n_cmp++;
         if (dut.io_en && command !== OP_PUSH) begin
            n_bad++;
            $display("FAIL bus_contention: io driven while COMMAND=%b (required 01)", command);
         end
      end
   end

   // Reference model: queue holds stack contents bottom..top.
   logic [W-1:0] ref_q [$];
   logic [W-1:0] last_rsp;

   task automatic model_reset();
      ref_q.delete();
      last_rsp = '0;
   endtask

   task automatic model_step(input logic [1:0] op, input logic [W-1:0] d, input int ix,
                             output int e_lat, output logic [W-1:0] e_data, output logic e_err);
      int n;
      bit rej;
      n   = ref_q.size();
      rej = 1'b0;
`ifdef STACK_SEQ_GUARD_EN
      rej = (op == OP_PUSH && n == D) || (op == OP_POP && n == 0) || (op == OP_GET && ix >= n);
`endif
      e_err = rej;
      if (rej) begin
         e_lat = 1; e_data = '0;
      end else if (op == OP_PUSH) begin
         if (n == D) void'(ref_q.pop_front());
         ref_q.push_back(d);
         e_lat = 1; e_data = last_rsp;
      end else if (op == OP_POP) begin
         e_lat = 2; e_data = ref_q.pop_back();
      end else begin
         e_lat = 2; e_data = ref_q[n - 1 - ix];
      end
      last_rsp = e_data;
   endtask

   // Drives one request starting at a falling edge; returns what was seen, ends on a falling edge.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] d, input logic [IW-1:0] ix,
                         output obs_t o);
      req_valid = 1'b1; req_op = op; req_data = d; req_index = ix;
      o.waited = 0;
      while (!req_ready && o.waited < 20) begin
         @(negedge clk);
         o.waited++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      req_op    = 2'($urandom);
      req_data  = W'($urandom);
      req_index = IW'($urandom);
      o.cmd     = command;
      o.idx     = index;
      o.busy_ok = !req_ready;
      o.lat     = 0;
      o.rdata   = '0;
      o.rerr    = 1'b0;
      for (int k = 1; k <= 6 && o.lat == 0; k++) begin
         @(negedge clk);
         if (req_ready) o.busy_ok = 1'b0;
         if (rsp_valid) begin
            o.lat = k; o.rdata = rsp_data; o.rerr = rsp_err;
         end
      end
      @(negedge clk);
      o.vld_after   = rsp_valid;
      o.ready_after = req_ready;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
      n_cmp++; if (rsp_data !== 4'h0) begin n_bad++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
      n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
      n_cmp++; if (command !== OP_NOP) begin n_bad++; $display("FAIL rst_command: got %b want 00", command); end
      n_cmp++; if (index !== 3'd0) begin n_bad++; $display("FAIL rst_index: got %0d want 0", index); end
      n_cmp++; if (dut.io_en !== 1'b0) begin n_bad++; $display("FAIL rst_io_hiz: driver enable %b want 0", dut.io_en); end
      n_cmp++; if (dut.occ !== 3'd0) begin n_bad++; $display("FAIL rst_occ: got %0d want 0", dut.occ); end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_push_pop();
      obs_t o;
      run_op(OP_PUSH, 4'd3, 3'd0, o);
      n_cmp++; if (o.waited !== 0) begin n_bad++; $display("FAIL first_accept_wait: got %0d want 0", o.waited); end
      n_cmp++; if (o.cmd !== OP_PUSH) begin n_bad++; $display("FAIL push3_cmd: got %b want 01", o.cmd); end
      n_cmp++; if (o.lat !== 1) begin n_bad++; $display("FAIL push3_lat: got %0d want 1", o.lat); end
      n_cmp++; if (o.rdata !== 4'd0) begin n_bad++; $display("FAIL push3_data_unchanged: got %h want 0", o.rdata); end
      n_cmp++; if (o.vld_after !== 1'b0 || o.ready_after !== 1'b1) begin n_bad++; $display("FAIL push3_end: valid %b ready %b want 0 1", o.vld_after, o.ready_after); end
      run_op(OP_PUSH, 4'd9, 3'd0, o);
      n_cmp++; if (o.lat !== 1 || o.rerr !== 1'b0) begin n_bad++; $display("FAIL push9: lat %0d err %b want 1 0", o.lat, o.rerr); end
      run_op(OP_POP, 4'd0, 3'd0, o);
      n_cmp++; if (o.cmd !== OP_POP) begin n_bad++; $display("FAIL pop_cmd: got %b want 10", o.cmd); end
      n_cmp++; if (o.lat !== 2) begin n_bad++; $display("FAIL pop_lat: got %0d want 2", o.lat); end
      n_cmp++; if (o.rdata !== 4'd9) begin n_bad++; $display("FAIL pop_data: got %h want 9", o.rdata); end
      n_cmp++; if (o.busy_ok !== 1'b1 || o.ready_after !== 1'b1) begin n_bad++; $display("FAIL pop_ready: busy_ok %b ready %b want 1 1", o.busy_ok, o.ready_after); end
      n_cmp++; if (dut.occ !== 3'd1) begin n_bad++; $display("FAIL pushpop_occ: got %0d want 1", dut.occ); end
   endtask

   task automatic test_get();
      obs_t o;
      apply_reset();
      for (int i = 1; i <= 3; i++) run_op(OP_PUSH, W'(i), 3'd0, o);
      run_op(OP_GET, 4'd0, 3'd2, o);
      n_cmp++; if (o.cmd !== OP_GET || o.idx !== 3'd2) begin n_bad++; $display("FAIL get2_bus: cmd %b idx %0d want 11 2", o.cmd, o.idx); end
      n_cmp++; if (o.lat !== 2 || o.rdata !== 4'd1) begin n_bad++; $display("FAIL get2: lat %0d data %h want 2 1", o.lat, o.rdata); end
      run_op(OP_GET, 4'd0, 3'd0, o);
      n_cmp++; if (o.rdata !== 4'd3) begin n_bad++; $display("FAIL get0: got %h want 3", o.rdata); end
      n_cmp++; if (dut.occ !== 3'd3) begin n_bad++; $display("FAIL get_occ: got %0d want 3", dut.occ); end
   endtask

   task automatic test_guard();
      obs_t o;
      apply_reset();
      run_op(OP_POP, 4'd0, 3'd0, o);
`ifdef STACK_SEQ_GUARD_EN
      n_cmp++; if (o.lat !== 1 || o.rerr !== 1'b1) begin n_bad++; $display("FAIL empty_pop: lat %0d err %b want 1 1", o.lat, o.rerr); end
      n_cmp++; if (o.cmd !== OP_NOP || o.rdata !== 4'd0) begin n_bad++; $display("FAIL empty_pop_bus: cmd %b data %h want 00 0", o.cmd, o.rdata); end
`else
      n_cmp++; if (o.lat !== 2 || o.rerr !== 1'b0) begin n_bad++; $display("FAIL empty_pop: lat %0d err %b want 2 0", o.lat, o.rerr); end
      n_cmp++; if (o.cmd !== OP_POP) begin n_bad++; $display("FAIL empty_pop_bus: cmd %b want 10", o.cmd); end
`endif
      n_cmp++; if (dut.occ !== 3'd0) begin n_bad++; $display("FAIL empty_pop_occ: got %0d want 0", dut.occ); end
      apply_reset();
      for (int i = 1; i <= 6; i++) begin
         run_op(OP_PUSH, W'(i), 3'd0, o);
`ifdef STACK_SEQ_GUARD_EN
         n_cmp++; if (o.rerr !== (i == 6) || o.lat !== 1) begin n_bad++; $display("FAIL push%0d_guard: err %b lat %0d want %b 1", i, o.rerr, o.lat, i == 6); end
         n_cmp++; if (o.cmd !== ((i == 6) ? OP_NOP : OP_PUSH)) begin n_bad++; $display("FAIL push%0d_cmd: got %b", i, o.cmd); end
`else
         n_cmp++; if (o.rerr !== 1'b0 || o.lat !== 1) begin n_bad++; $display("FAIL push%0d_noguard: err %b lat %0d want 0 1", i, o.rerr, o.lat); end
`endif
      end
      n_cmp++; if (dut.occ !== 3'd5) begin n_bad++; $display("FAIL full_occ: got %0d want 5", dut.occ); end
      run_op(OP_POP, 4'd0, 3'd0, o);
`ifdef STACK_SEQ_GUARD_EN
      n_cmp++; if (o.rdata !== 4'd5) begin n_bad++; $display("FAIL full_pop: got %h want 5", o.rdata); end
      run_op(OP_GET, 4'd0, 3'd4, o);
      n_cmp++; if (o.rerr !== 1'b1 || o.lat !== 1 || o.cmd !== OP_NOP) begin n_bad++; $display("FAIL get_oob: err %b lat %0d cmd %b want 1 1 00", o.rerr, o.lat, o.cmd); end
`else
      n_cmp++; if (o.rdata !== 4'd6) begin n_bad++; $display("FAIL wrap_pop: got %h want 6", o.rdata); end
`endif
      n_cmp++; if (dut.occ !== 3'd4) begin n_bad++; $display("FAIL after_pop_occ: got %0d want 4", dut.occ); end
   endtask

   task automatic test_idle_nop();
      apply_reset();
      req_valid = 1'b1;
      req_op    = OP_NOP;
      for (int i = 0; i < 8; i++) begin
         req_data  = W'($urandom);
         req_index = IW'($urandom);
         @(negedge clk);
         n_cmp++; if (req_ready !== 1'b1 || command !== OP_NOP) begin n_bad++; $display("FAIL nop_%0d: ready %b cmd %b want 1 00", i, req_ready, command); end
      end
      req_valid = 1'b0;
      n_cmp++; if (dut.occ !== 3'd0) begin n_bad++; $display("FAIL nop_occ: got %0d want 0", dut.occ); end
   endtask

   task automatic test_reset_capture();
      obs_t o;
      logic seen;
      apply_reset();
      run_op(OP_PUSH, 4'd4, 3'd0, o);
      run_op(OP_PUSH, 4'd5, 3'd0, o);
      run_op(OP_PUSH, 4'd6, 3'd0, o);
      run_op(OP_POP, 4'd0, 3'd0, o);
      n_cmp++; if (o.rdata !== 4'd6) begin n_bad++; $display("FAIL pre_reset_pop: got %h want 6", o.rdata); end
      req_valid = 1'b1; req_op = OP_POP;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++; if (dut.io_en !== 1'b0 || command !== OP_NOP) begin n_bad++; $display("FAIL midrst_bus: io_en %b cmd %b want 0 00", dut.io_en, command); end
      n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_hs: ready %b valid %b want 1 0", req_ready, rsp_valid); end
      n_cmp++; if (rsp_data !== 4'd0 || dut.occ !== 3'd0) begin n_bad++; $display("FAIL midrst_state: data %h occ %0d want 0 0", rsp_data, dut.occ); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_no_rsp: got %b want 0", seen); end
      run_op(OP_PUSH, 4'd7, 3'd0, o);
      run_op(OP_POP, 4'd0, 3'd0, o);
      n_cmp++; if (o.lat !== 2 || o.rdata !== 4'd7) begin n_bad++; $display("FAIL post_rst_pop: lat %0d data %h want 2 7", o.lat, o.rdata); end
   endtask

   task automatic test_random();
      obs_t         o;
      int           e_lat;
      logic [W-1:0] e_data;
      logic         e_err;
      logic [1:0]   op;
      logic [W-1:0] d;
      int           ix;
      int           n;
      apply_reset();
      for (int t = 0; t < 60; t++) begin
         n = ref_q.size();
`ifdef STACK_SEQ_GUARD_EN
         op = 2'($urandom_range(1, 3));
         ix = $urandom_range(0, 7);
`else
         if (n == 0) op = OP_PUSH;
         else if (n == D) op = 2'($urandom_range(2, 3));
         else op = 2'($urandom_range(1, 3));
         ix = (n > 0) ? $urandom_range(0, n - 1) : 0;
`endif
         d = W'($urandom);
         model_step(op, d, ix, e_lat, e_data, e_err);
         run_op(op, d, IW'(ix), o);
         n_cmp++; if (o.lat !== e_lat || o.rerr !== e_err) begin n_bad++; $display("FAIL rnd%0d_rsp: op %b lat %0d err %b want %0d %b", t, op, o.lat, o.rerr, e_lat, e_err); end
         n_cmp++; if (o.rdata !== e_data) begin n_bad++; $display("FAIL rnd%0d_data: op %b got %h want %h", t, op, o.rdata, e_data); end
         n_cmp++; if (o.cmd !== (e_err ? OP_NOP : op)) begin n_bad++; $display("FAIL rnd%0d_cmd: got %b want %b", t, o.cmd, e_err ? OP_NOP : op); end
         if (!e_err && op == OP_GET) begin
            n_cmp++; if (o.idx !== IW'(ix)) begin n_bad++; $display("FAIL rnd%0d_idx: got %0d want %0d", t, o.idx, ix); end
         end
         n_cmp++; if (o.busy_ok !== 1'b1 || o.vld_after !== 1'b0 || o.ready_after !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_hs: busy_ok %b vld_after %b ready %b want 1 0 1", t, o.busy_ok, o.vld_after, o.ready_after); end
         n_cmp++; if (int'(dut.occ) !== ref_q.size()) begin n_bad++; $display("FAIL rnd%0d_occ: got %0d want %0d", t, dut.occ, ref_q.size()); end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_push_pop();
      test_get();
      test_guard();
      test_idle_nop();
      test_reset_capture();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
